// File: rtl/instr_encoder_if.sv
// Request/response bundle between the loader front end and the encoder.
// The request side carries instruction fields; the response side carries
// the encoded word and its instruction-memory word address.
interface instr_encoder_if #(
  parameter int ADDR_WIDTH = 10
);
  logic                  in_valid;
  logic                  in_ready;
  logic [4:0]            in_op;
  logic [2:0]            in_funct3;
  logic                  in_arith;
  logic [4:0]            in_rd;
  logic [4:0]            in_rs1;
  logic [4:0]            in_rs2;
  logic [31:0]           in_imm;
  logic                  out_valid;
  logic                  out_ready;
  logic [31:0]           out_instr;
  logic [ADDR_WIDTH-1:0] out_addr;

  // Producer of requests and consumer of encoded words.
  modport master (
    output in_valid, in_op, in_funct3, in_arith, in_rd, in_rs1, in_rs2, in_imm,
    input  in_ready,
    input  out_valid, out_instr, out_addr,
    output out_ready
  );

  // The encoder itself.
  modport slave (
    input  in_valid, in_op, in_funct3, in_arith, in_rd, in_rs1, in_rs2, in_imm,
    output in_ready,
    output out_valid, out_instr, out_addr,
    input  out_ready
  );
endinterface

// File: rtl/instr_encoder.sv
// Streaming RV32I instruction encoder: turns instruction fields into a
// 32-bit word tagged with a dense, wrapping word address. Bad requests are
// still consumed, emitted as NOP, and reported through a sticky error flag.
module instr_encoder #(
  parameter int          ADDR_WIDTH = 10,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  instr_encoder_if.slave      bus,
  input  logic                clear,
  output logic                err,
  output logic [1:0]          err_code
);

  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [31:0]           NOP  = 32'h0000_0013;

  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_OP_IMM = 5'b00100;
  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JAL    = 5'b11011;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_RANGE   = 2'b10;
  localparam logic [1:0] ERR_ALIGN   = 2'b11;

  logic                  out_valid_q;
  logic [31:0]           out_instr_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  accept;
  logic                  fire;

  logic [4:0]  op;
  logic [2:0]  f3;
  logic        arith;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] imm;

  logic        i_fits;
  logic        b_fits;
  logic        j_fits;
  logic        illegal;
  logic        misaligned;
  logic        out_of_range;
  logic [31:0] raw_word;
  logic [31:0] enc_word;
  logic [1:0]  enc_code;

  assign op    = bus.in_op;
  assign f3    = bus.in_funct3;
  assign arith = bus.in_arith;
  assign rd    = bus.in_rd;
  assign rs1   = bus.in_rs1;
  assign rs2   = bus.in_rs2;
  assign imm   = bus.in_imm;

  // Sign-extension checks: the bits above each format's field must all
  // match the sign bit for the value to be representable.
  assign i_fits = (imm[31:11] == {21{imm[31]}});
  assign b_fits = (imm[31:12] == {20{imm[31]}});
  assign j_fits = (imm[31:20] == {12{imm[31]}});

  assign fire         = out_valid_q && bus.out_ready;
  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  assign bus.out_valid = out_valid_q;
  assign bus.out_instr = out_instr_q;
  assign bus.out_addr  = addr_q;

  // Build the instruction word for the requested format and classify any fault.
  always_comb begin
    raw_word     = NOP;
    illegal      = 1'b0;
    misaligned   = 1'b0;
    out_of_range = 1'b0;
    case (op)
      OPC_OP: begin
        illegal  = arith && (f3 != 3'b000) && (f3 != 3'b101);
        raw_word = {1'b0, arith, 5'b0, rs2, rs1, f3, rd, OPC_OP, 2'b11};
      end
      OPC_OP_IMM: begin
        if ((f3 == 3'b001) || (f3 == 3'b101)) begin
          illegal      = arith && (f3 == 3'b001);
          out_of_range = |imm[31:5];
          raw_word     = {1'b0, arith, 5'b0, imm[4:0], rs1, f3, rd, OPC_OP_IMM, 2'b11};
        end else begin
          out_of_range = !i_fits;
          raw_word     = {imm[11:0], rs1, f3, rd, OPC_OP_IMM, 2'b11};
        end
      end
      OPC_LOAD: begin
        illegal      = !(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        out_of_range = !i_fits;
        raw_word     = {imm[11:0], rs1, f3, rd, OPC_LOAD, 2'b11};
      end
      OPC_STORE: begin
        illegal      = !(f3 inside {3'b000, 3'b001, 3'b010});
        out_of_range = !i_fits;
        raw_word     = {imm[11:5], rs2, rs1, f3, imm[4:0], OPC_STORE, 2'b11};
      end
      OPC_BRANCH: begin
        illegal      = (f3 == 3'b010) || (f3 == 3'b011);
        misaligned   = imm[0];
        out_of_range = !b_fits;
        raw_word     = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OPC_BRANCH, 2'b11};
      end
      OPC_JAL: begin
        misaligned   = imm[0];
        out_of_range = !j_fits;
        raw_word     = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL, 2'b11};
      end
      OPC_JALR: begin
        illegal      = (f3 != 3'b000);
        out_of_range = !i_fits;
        raw_word     = {imm[11:0], rs1, f3, rd, OPC_JALR, 2'b11};
      end
      OPC_LUI, OPC_AUIPC: begin
        out_of_range = |imm[11:0];
        raw_word     = {imm[31:12], rd, op, 2'b11};
      end
      default: begin
        illegal = 1'b1;
      end
    endcase

    if (illegal) begin
      enc_code = ERR_ILLEGAL;
    end else if (misaligned) begin
      enc_code = ERR_ALIGN;
    end else if (out_of_range) begin
      enc_code = ERR_RANGE;
    end else begin
      enc_code = ERR_NONE;
    end
    enc_word = (enc_code == ERR_NONE) ? raw_word : NOP;
  end

  // Single output register: load on acceptance, drop valid once drained.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_instr_q <= enc_word;
    end else if (fire) begin
      out_valid_q <= 1'b0;
    end
  end

  // Word-address counter advances per delivered word; clear takes priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= BASE;
    end else if (clear) begin
      addr_q <= BASE;
    end else if (fire) begin
      addr_q <= addr_q + 1'b1;
    end
  end

  // Sticky error: keep the first code; a new error in a clear cycle still lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err      <= 1'b0;
      err_code <= ERR_NONE;
    end else if (accept && (enc_code != ERR_NONE)) begin
      err <= 1'b1;
      if (!err || clear) begin
        err_code <= enc_code;
      end
    end else if (clear) begin
      err      <= 1'b0;
      err_code <= ERR_NONE;
    end
  end

endmodule
